// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and execute FSM states.
// Imported by the ALU control decoder and the EX-stage execute unit.
package alu_pkg;

  localparam logic [3:0] ALU_NOP  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_OR   = 4'b1001;
  localparam logic [3:0] ALU_AND  = 4'b1010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle evaluator for all non-shift ALU ops plus illegal-code flag.
// Ports: alu_control, op_a, op_b in; result, illegal out. Shifts yield 0.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  logic lt_s;
  logic lt_u;

  assign lt_s = $signed(op_a) < $signed(op_b);
  assign lt_u = op_a < op_b;

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    unique case (alu_control)
      ALU_NOP:  result = '0;
      ALU_ADD:  result = op_a + op_b;
      ALU_SUB:  result = op_a - op_b;
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, lt_s};
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, lt_u};
      ALU_XOR:  result = op_a ^ op_b;
      ALU_OR:   result = op_a | op_b;
      ALU_AND:  result = op_a & op_b;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  result = '0;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq_exec.sv
// EX-stage multi-cycle ALU with valid/ready handshakes and zero flag.
// Ports: clk, rst, in_valid/in_ready, alu_control, op_a, op_b,
// out_valid/out_ready, result, zero, illegal.
// ALU_SEQ_BARREL_SHIFT_EN: single-cycle barrel shifts (no SHIFT state).
module alu_seq_exec
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  state_t state;

  logic [WIDTH-1:0]   core_res;
  logic               core_ill;
  logic [WIDTH-1:0]   nxt_res;
  logic [SHAMT_W-1:0] shamt;
  logic               is_shift;
  logic               accept;

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .alu_control (alu_control),
    .op_a        (op_a),
    .op_b        (op_b),
    .result      (core_res),
    .illegal     (core_ill)
  );

  assign shamt    = op_b[SHAMT_W-1:0];
  assign is_shift = (alu_control == ALU_SLL) ||
                    (alu_control == ALU_SRL) ||
                    (alu_control == ALU_SRA);
  assign accept    = in_valid && in_ready;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

`ifdef ALU_SEQ_BARREL_SHIFT_EN
  logic [WIDTH-1:0] shf;

  always_comb begin
    shf = op_a;
    if (alu_control == ALU_SLL)
      shf = op_a << shamt;
    else if (alu_control == ALU_SRL)
      shf = op_a >> shamt;
    else if (alu_control == ALU_SRA)
      shf = WIDTH'($signed(op_a) >>> shamt);
  end

  assign nxt_res = is_shift ? shf : core_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      result  <= '0;
      zero    <= 1'b1;
      illegal <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          result  <= nxt_res;
          zero    <= (nxt_res == '0);
          illegal <= core_ill;
          state   <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic [SHAMT_W-1:0] cnt;
  logic [3:0]         ctrl_q;
  logic [WIDTH-1:0]   step;
  logic               go_shift;

  // Serial path seeds result with op_a; shamt==0 finishes at once.
  assign nxt_res  = is_shift ? op_a : core_res;
  assign go_shift = is_shift && (shamt != '0);

  always_comb begin
    step = result;
    if (ctrl_q == ALU_SLL)
      step = result << 1;
    else if (ctrl_q == ALU_SRL)
      step = result >> 1;
    else if (ctrl_q == ALU_SRA)
      step = {result[WIDTH-1], result[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      result  <= '0;
      zero    <= 1'b1;
      illegal <= 1'b0;
      cnt     <= '0;
      ctrl_q  <= ALU_NOP;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          result  <= nxt_res;
          zero    <= (nxt_res == '0);
          illegal <= core_ill;
          cnt     <= shamt;
          ctrl_q  <= alu_control;
          state   <= go_shift ? SHIFT : DONE;
        end
        SHIFT: begin
          result <= step;
          zero   <= (step == '0);
          cnt    <= cnt - 1'b1;
          if (cnt == SHAMT_W'(1)) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed-vector bench for alu_seq_exec.
// Hand-computed expectations checked with immediate assertions.
module tb_alu_seq_exec;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int vectors;
  int miscompares;

  alu_seq_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .op_a        (op_a),
    .op_b        (op_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ALU_SEQ_BARREL_SHIFT_EN
  localparam int LAT31 = 1;
`else
  localparam int LAT31 = 32;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] c,
                       input logic [31:0] a,
                       input logic [31:0] b);
    alu_control = c;
    op_a        = a;
    op_b        = b;
    in_valid    = 1'b1;
    tick();
    in_valid    = 1'b0;
    op_a        = 32'hDEAD_BEEF;
    op_b        = 32'h0000_0007;
    alu_control = ALU_AND;
  endtask

  // Returns cycles from acceptance to out_valid; in_ready high while
  // waiting is counted in busy_rdy.
  task automatic wait_out(output int lat, output int busy_rdy);
    lat      = 1;
    busy_rdy = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_rdy++;
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [3:0] c,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp_res,
                        input logic exp_zero,
                        input logic exp_ill,
                        input int exp_lat);
    int lat;
    int br;
    issue(c, a, b);
    wait_out(lat, br);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy_rdy"}, 32'(br), 32'd0);
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_zero});
    chk({tag, "_ill"}, {31'd0, illegal}, {31'd0, exp_ill});
    tick();
  endtask

  initial begin
    int lat;
    int br;
    int seen;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    alu_control = ALU_NOP;
    op_a        = '0;
    op_b        = '0;

    #3;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);

    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    tick();

    run_op("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'h1,
           32'h8000_0000, 1'b0, 1'b0, 1);
    run_op("sub_eq", ALU_SUB, 32'd5, 32'd5,
           32'h0, 1'b1, 1'b0, 1);
    run_op("slt", ALU_SLT, 32'hFFFF_FFFF, 32'h1,
           32'h1, 1'b0, 1'b0, 1);
    run_op("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'h1,
           32'h0, 1'b1, 1'b0, 1);
    run_op("or", ALU_OR, 32'h0000_00A0, 32'h0000_0005,
           32'h0000_00A5, 1'b0, 1'b0, 1);
    run_op("and", ALU_AND, 32'hFFFF_00FF, 32'h0F0F_0F0F,
           32'h0F0F_000F, 1'b0, 1'b0, 1);
    run_op("nop", ALU_NOP, 32'h1234, 32'h5678,
           32'h0, 1'b1, 1'b0, 1);
    run_op("sra31", ALU_SRA, 32'h8000_0000, 32'd31,
           32'hFFFF_FFFF, 1'b0, 1'b0, LAT31);
    run_op("srl31", ALU_SRL, 32'h8000_0000, 32'd31,
           32'h0000_0001, 1'b0, 1'b0, LAT31);
    run_op("sll0", ALU_SLL, 32'h0000_1234, 32'h20,
           32'h0000_1234, 1'b0, 1'b0, 1);
    run_op("sll4", ALU_SLL, 32'h0000_1234, 32'h4,
           32'h0001_2340, 1'b0, 1'b0, 5);

    // Back-pressure: result held, in_valid pulses ignored.
    out_ready = 1'b0;
    issue(ALU_XOR, 32'h0000_F0F0, 32'h0000_0FF0);
    wait_out(lat, br);
    chk("stall_lat", 32'(lat), 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid    = i[0] ? 1'b0 : 1'b1;
      alu_control = ALU_ADD;
      op_a        = 32'd1;
      op_b        = 32'd1;
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_rdy", {31'd0, in_ready}, 32'd0);
      chk("stall_res", result, 32'h0000_FF00);
      chk("stall_zero", {31'd0, zero}, 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("post_stall_rdy", {31'd0, in_ready}, 32'd1);
    chk("post_stall_valid", {31'd0, out_valid}, 32'd0);

    // Reset three cycles into a 20-bit shift aborts it.
    issue(ALU_SLL, 32'h1, 32'd20);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_rdy", {31'd0, in_ready}, 32'd1);
    chk("abort_res", result, 32'd0);
    chk("abort_zero", {31'd0, zero}, 32'd1);
    tick();
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("abort_no_pulse", 32'(seen), 32'd0);

    run_op("add_after", ALU_ADD, 32'd2, 32'd3,
           32'd5, 1'b0, 1'b0, 1);
    run_op("illegal", 4'b1101, 32'h55, 32'hAA,
           32'h0, 1'b1, 1'b1, 1);
    run_op("clr_ill", ALU_ADD, 32'd1, 32'd0,
           32'd1, 1'b0, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
- Multi-cycle execute unit that consumes the 4-bit alu_control encoding produced by the ALU control decoder and performs the selected operation on two operands.
- Sits in the EX stage between the decoder and the writeback/branch logic.
- Uses a valid/ready handshake on input and output so the pipeline can stall while the serial shifter works.
- Also supplies the zero flag consumed by branch resolution (beq/bne via sub; blt/bge/bltu/bgeu via slt/sltu bit 0).

Parameters:
- WIDTH, 32, operand and result width in bits; power of two, at least 8.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operation request valid
- in_ready  output  1  unit can accept a request
- alu_control  input  4  operation code (encoding below)
- op_a  input  WIDTH  operand A (rs1 / PC)
- op_b  input  WIDTH  operand B (rs2 / immediate); shift amount = op_b[SHAMT_W-1:0]
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  operation result
- zero  output  1  result == 0
- illegal  output  1  alu_control was not a defined code

Behaviour:
- Reset is asynchronous and active-high on rst, with one clock clk. On reset: state=IDLE, in_ready=1, out_valid=0, result=0, zero=1, illegal=0, internal shift counter=0.
- Encoding:
  - 0001 add, 0010 sub, 0011 sll, 0100 slt (signed), 0101 sltu
  - 0110 xor, 0111 srl, 1000 sra, 1001 or, 1010 and
  - 0000 nop: result=0, illegal=0
  - 1011-1111: result=0, illegal=1
- Arithmetic: add/sub wrap modulo 2^WIDTH, no carry or overflow output. slt/sltu return {WIDTH-1 zeros, flag}.
- FSM states:
  - IDLE: in_ready=1. Handshake occurs when in_valid&&in_ready.
    - Non-shift op: compute combinationally, register into result, go to DONE. out_valid rises the cycle after acceptance (latency 1).
    - Shift op with shamt==0: result=op_a, go to DONE (latency 1).
    - Shift op with shamt>0: latch op_a into result, load counter=shamt, go to SHIFT.
  - SHIFT: in_ready=0. Each cycle, shift result by exactly 1 bit (sll: zero-fill LSB; srl: zero-fill MSB; sra: replicate MSB) and decrement counter. When counter==1 on the final shift, go to DONE. Total latency = shamt+1 cycles; maximum WIDTH cycles.
  - DONE: out_valid=1, in_ready=0. result, zero and illegal are held stable until out_ready. On out_valid&&out_ready, go to IDLE. No request can be accepted in the same cycle as the output transfer; throughput is at most one op per 2 cycles.
- zero is registered together with result and always reflects the held result.
- in_valid outside IDLE is ignored. Operand and control inputs are sampled only at acceptance; later changes have no effect.
- Reset asserted mid-SHIFT or mid-DONE aborts the operation immediately. The pending result is discarded and no out_valid pulse occurs.

Optional Feature:
- Macro ALU_SEQ_BARREL_SHIFT_EN.
- Defined: shifts use a single-cycle barrel shifter and have latency 1 like every other op. The SHIFT state and counter are not generated.
- Undefined (default): serial 1-bit-per-cycle shifter as described above.
- Function results are identical in both builds; only latency differs.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_NOP/ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND 4-bit localparams, reused by the decoder.
  - FSM state encoding IDLE/SHIFT/DONE.
- One natural sub-module: alu_comb_core, a purely combinational single-cycle evaluator for all non-shift ops plus the illegal flag. The FSM and shifter live in the top module.

Test Plan:
- add 0x7FFFFFFF+0x00000001 with out_ready=1 -> out_valid one cycle after accept, result=0x80000000, zero=0; sub 5-5 -> result=0, zero=1.
- slt op_a=0xFFFFFFFF, op_b=1 -> result=1; sltu with the same operands -> result=0.
- sra 0x80000000 by 31 -> in_ready low for 31 cycles, out_valid at cycle 32, result=0xFFFFFFFF; srl with the same operands -> 0x00000001.
- sll shamt=0 (op_b=0x20, only low 5 bits used) with op_a=0x1234 -> latency 1, result=0x1234.
- out_ready held low 5 cycles after result -> out_valid, result and zero stay stable; in_valid pulses during that window are ignored (in_ready=0).
- rst pulsed at cycle 3 of a 20-cycle shift -> outputs return to reset values asynchronously, no out_valid; next add 2+3 returns 5. Also: alu_control=1101 -> illegal=1, result=0, zero=1.
